rc4_ksa_shuffle: RTL
====================

# rc4_ksa_shuffle

RC4 key-scheduling swap stage: walks i = 0..255 over the 256-byte S RAM, accumulates j = j + S[i] + key[i mod KEY_BYTES] and swaps S[i] and S[j]. It sits directly downstream of the S-initialisation stage and upstream of the decrypt stage. The top-level controller pulses `start` and waits for `finish`, routing the S RAM ports to this block while it is selected.

## Interface
- `KEY_BYTES`, default 3: number of key bytes; key index wraps modulo this value.
- `clk`  in  1: clock.
- `rst`  in  1: reset, synchronous, active-high; clock clk.
- `start`  in  1: one-cycle request; sampled only in IDLE.
- `key`  in  8*KEY_BYTES: secret key. Byte n is `key[8*(KEY_BYTES-n)-1 -: 8]`, so the MSB byte is byte 0. Registered on accepted `start`.
- `finish`  out  1: one-cycle completion pulse.
- `busy`  out  1: high from the first cycle after `start` is accepted until the cycle before `finish`.
- `s_addr`  out  8: S RAM address.
- `s_wdata`  out  8: S RAM write data.
- `s_wren`  out  1: S RAM write enable.
- `s_rdata`  in  8: S RAM read data. Valid the cycle after the address is presented (1-cycle latency).

## Operation
- Registers:
  - `i` (8b), `j` (8b).
  - `k`: key index, 0..KEY_BYTES-1, a wrap counter with no divider.
  - `si`, `sj` (8b each).
  - `key_q`.
- States and per-state actions:
  - IDLE: outputs quiescent. If `start`: latch key, i=j=k=0, go to RD_I.
  - RD_I: s_addr=i. Go to CAP_I.
  - CAP_I: si=s_rdata; j = j + s_rdata + key_q byte k (mod 256). Go to RD_J.
  - RD_J: s_addr=j (updated). Go to CAP_J.
  - CAP_J: sj=s_rdata. Go to WR_I.
  - WR_I: s_addr=i, s_wdata=sj, s_wren=1. Go to WR_J.
  - WR_J: s_addr=j, s_wdata=si, s_wren=1. Then:
    - k wraps to 0 at KEY_BYTES-1, else increments.
    - If i==255 go to DONE; else i=i+1 and go to RD_I.
  - DONE: finish=1. Go to IDLE.
  - Any illegal state goes to IDLE.
- All arithmetic is 8-bit, wrap-around mod 256, carries discarded.
- i==j: both writes target the same address with the same value; no special-casing.
- `s_wren` is 0 in every state except WR_I and WR_J. `s_addr` and `s_wdata` are don't-care outside RD and WR states but are driven 0 in IDLE and DONE.
- `start` is ignored when not in IDLE, including in DONE. `key` changes after acceptance have no effect.
- Reset, including mid-run: next state IDLE and i=j=k=0. S RAM contents are left as-is, partially shuffled; the controller restarts from init.

## Timing
- Reset values: finish=0, busy=0, s_wren=0, s_addr=0, s_wdata=0.
- Outputs are registered or decoded from state, with no combinational path from `s_rdata` to any output.
- Each iteration is 6 cycles; the run is 256 × 6 = 1536 cycles.
- Taking the edge that samples `start` as edge 0:
  - RD_I of iteration 0 is cycle 1.
  - Iteration n occupies cycles 6n+1 .. 6n+6.
  - `busy` is high in cycles 1..1536.
  - `finish` is high in cycle 1537 only.
- Write counts: exactly 512 `s_wren` cycles per run, 2 per iteration, always consecutive.
- A `start` in the cycle after `finish` (state IDLE) is accepted: a back-to-back run with no gap penalty.

## Test plan
- Key 0x010203, RAM preset S[x]=x, iteration 0: read addr 0 → 0, j=1; read addr 1 → 1; write addr0=1 then addr1=0 in cycles 5,6.
- Key 0x000000, S[x]=x:
  - Iterations 0 and 1 have i==j and rewrite the same values.
  - Iteration 2 gives j=3 and writes addr2=3, addr3=2.
  - Full run matches a software KSA model byte-for-byte across all 256 entries.
- Cycle counting: `finish` is a single-cycle pulse exactly 1537 cycles after `start`. `busy` is high for 1536 cycles. Exactly 512 write strobes occur. `s_wren`=0 in all RD and CAP cycles.
- `start` pulses at cycles 10 and 1537 are ignored. `key` changed to 0xFFFFFF at cycle 100 does not alter the final RAM versus the model with the original key. `start` at cycle 1538 begins a second run.
- KEY_BYTES=3 wrap: iteration 3 uses key byte 0 (0x01 for key 0x010203), confirmed via the j value observed on `s_addr` in RD_J.
- `rst` asserted at cycle 700:
  - All outputs are 0 in cycle 701 and the block is in IDLE.
  - A fresh `start` with RAM re-preset runs a full 1537-cycle sequence matching the model, with j starting at 0.

Source files
------------

// File: rtl/rc4_ksa_shuffle_if.sv
// RC4 KSA swap-stage bus: start/finish handshake, secret key and the S RAM port.
//   start, key           : request from the controller
//   finish, busy         : completion pulse and run-in-progress flag
//   s_addr/s_wdata/s_wren: S RAM address, write data, write enable
//   s_rdata              : S RAM read data (1-cycle latency)
// master = controller/RAM side, slave = shuffle engine.
interface rc4_ksa_shuffle_if #(
  parameter int unsigned KEY_BYTES = 3
);
  logic                   start;
  logic [8*KEY_BYTES-1:0] key;
  logic                   finish;
  logic                   busy;
  logic [7:0]             s_addr;
  logic [7:0]             s_wdata;
  logic                   s_wren;
  logic [7:0]             s_rdata;

  modport master (
    output start, key, s_rdata,
    input  finish, busy, s_addr, s_wdata, s_wren
  );

  modport slave (
    input  start, key, s_rdata,
    output finish, busy, s_addr, s_wdata, s_wren
  );
endinterface

// File: rtl/rc4_ksa_shuffle.sv
// RC4 key-scheduling swap stage: for i = 0..255, j += S[i] + key[i mod KEY_BYTES],
// then swap S[i] and S[j] through a single-port S RAM with 1-cycle read latency.
// Ports:
//   clk, rst : clock, synchronous active-high reset
//   bus      : slave side of rc4_ksa_shuffle_if (start/key in, finish/busy out,
//              S RAM address/write data/write enable out, read data in)
// Each iteration takes 6 cycles (RD_I, CAP_I, RD_J, CAP_J, WR_I, WR_J); all
// outputs are registered so s_rdata never reaches an output combinationally.
module rc4_ksa_shuffle #(
  parameter int unsigned KEY_BYTES = 3
) (
  input  logic              clk,
  input  logic              rst,
  rc4_ksa_shuffle_if.slave  bus
);

  localparam int unsigned KEY_W = 8 * KEY_BYTES;
  localparam int unsigned K_W   = (KEY_BYTES > 1) ? $clog2(KEY_BYTES) : 1;
  localparam logic [K_W-1:0] K_LAST = K_W'(KEY_BYTES - 1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    RD_I  = 3'd1,
    CAP_I = 3'd2,
    RD_J  = 3'd3,
    CAP_J = 3'd4,
    WR_I  = 3'd5,
    WR_J  = 3'd6,
    DONE  = 3'd7
  } state_t;

  state_t           state;
  logic [7:0]       i;
  logic [7:0]       j;
  logic [K_W-1:0]   k;
  logic [7:0]       si;
  logic [KEY_W-1:0] key_q;

  logic             finish;
  logic             busy;
  logic [7:0]       s_addr;
  logic [7:0]       s_wdata;
  logic             s_wren;

  logic [7:0]       key_byte;
  logic [7:0]       j_next;

  // Key byte k; byte 0 is the most significant byte of key_q.
  always_comb begin
    key_byte = '0;
    for (int n = 0; n < KEY_BYTES; n++) begin
      if (k == K_W'(n)) key_byte = key_q[8*(KEY_BYTES-n)-1 -: 8];
    end
  end

  // Updated j, computed from S[i] as it arrives (mod 256).
  assign j_next = j + bus.s_rdata + key_byte;

  // State machine with registered outputs; each branch loads the outputs
  // belonging to the state being entered.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      i       <= '0;
      j       <= '0;
      k       <= '0;
      si      <= '0;
      key_q   <= '0;
      finish  <= 1'b0;
      busy    <= 1'b0;
      s_addr  <= '0;
      s_wdata <= '0;
      s_wren  <= 1'b0;
    end else begin
      finish <= 1'b0;
      s_wren <= 1'b0;
      case (state)
        IDLE: begin
          busy    <= 1'b0;
          s_addr  <= '0;
          s_wdata <= '0;
          if (bus.start) begin
            key_q <= bus.key;
            i     <= '0;
            j     <= '0;
            k     <= '0;
            busy  <= 1'b1;
            state <= RD_I;
          end
        end
        RD_I: begin
          state <= CAP_I;
        end
        CAP_I: begin
          si     <= bus.s_rdata;
          j      <= j_next;
          s_addr <= j_next;
          state  <= RD_J;
        end
        RD_J: begin
          state <= CAP_J;
        end
        CAP_J: begin
          // S[j] goes straight into the write-data register; it is only
          // needed for the WR_I write.
          s_addr  <= i;
          s_wdata <= bus.s_rdata;
          s_wren  <= 1'b1;
          state   <= WR_I;
        end
        WR_I: begin
          s_addr  <= j;
          s_wdata <= si;
          s_wren  <= 1'b1;
          state   <= WR_J;
        end
        WR_J: begin
          k <= (k == K_LAST) ? '0 : k + K_W'(1);
          if (i == 8'hFF) begin
            busy    <= 1'b0;
            finish  <= 1'b1;
            s_addr  <= '0;
            s_wdata <= '0;
            state   <= DONE;
          end else begin
            i      <= i + 8'd1;
            s_addr <= i + 8'd1;
            state  <= RD_I;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          busy    <= 1'b0;
          s_addr  <= '0;
          s_wdata <= '0;
          state   <= IDLE;
        end
      endcase
    end
  end

  assign bus.finish  = finish;
  assign bus.busy    = busy;
  assign bus.s_addr  = s_addr;
  assign bus.s_wdata = s_wdata;
  assign bus.s_wren  = s_wren;

endmodule
